// File: rtl/serial_sub_ctrl_pkg.sv
// serial_sub_ctrl_pkg: shared state encoding and default width for the serial subtractor
package serial_sub_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_sub_ctrl_full_sub.sv
// full_sub: behavioural 1-bit full subtractor
module full_sub (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);
  assign d = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: computes a - b LSB first over WIDTH cycles with one shared full subtractor
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CNT_W-1:0] cnt;
  logic brw, d, bo, load, last;
  full_sub u_fs (.a(a_sr[0]), .b(b_sr[0]), .borrow_in(brw), .d(d), .borrow_out(bo));
  always_comb begin
    load = (state != RUN) && start;
    last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    busy = state == RUN;
    done = state == DONE;
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      res_sr <= '0;
      brw <= 1'b0;
      cnt <= '0;
      diff <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        a_sr <= a;
        b_sr <= b;
        brw <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        res_sr <= {d, res_sr[WIDTH-1:1]};
        brw <= bo;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          diff <= {d, res_sr[WIDTH-1:1]};
          borrow_out <= bo;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed table, corner sequences and random sweep at WIDTH 8 and 13
module tb_serial_sub_ctrl;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start = 1'b0, busy, done, borrow_out;
  logic [7:0] a = '0, b = '0, diff;
  logic start13 = 1'b0, busy13, done13, bo13;
  logic [12:0] a13 = '0, b13 = '0, diff13;
  int n_cmp = 0, n_fail = 0;
  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out));
  serial_sub_ctrl #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_done(output int lat, output int nbusy, output int ovl);
    lat = 0;
    nbusy = 0;
    ovl = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy && done) ovl++;
      if (busy) nbusy++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask
  vec_t vecs[6];
  int lat, nbusy, ovl, nd;
  logic [7:0] x8, y8;
  logic [12:0] x13, y13;
  logic g8, g13;
  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hA7, 8'hA7, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    repeat (2) @(negedge clk);
    check("reset8", {busy, done, borrow_out, diff}, '0);
    check("reset13", {busy13, done13, bo13, diff13}, '0);
    rst = 1'b0;
    foreach (vecs[k]) begin
      @(negedge clk);
      start = 1'b1;
      a = vecs[k].a;
      b = vecs[k].b;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      wait_done(lat, nbusy, ovl);
      check("vec_latency", 64'(lat), 64'd9);
      check("vec_busy_cycles", 64'(nbusy), 64'd8);
      check("vec_overlap", 64'(ovl), 64'd0);
      check("vec_result", {borrow_out, diff}, {vecs[k].bo, vecs[k].d});
      @(negedge clk);
      check("vec_idle_after", {busy, done}, 2'b00);
      check("vec_hold", {borrow_out, diff}, {vecs[k].bo, vecs[k].d});
    end
    @(negedge clk);
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy, ovl);
    check("ign_latency", 64'(lat), 64'd6);
    check("ign_result", {borrow_out, diff}, {1'b0, 8'h0F});
    count_done(15, nd);
    check("ign_single_done", 64'(nd), 64'd0);
    @(negedge clk);
    start = 1'b1;
    a = 8'h5A;
    b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run", {busy, done, borrow_out, diff}, '0);
    count_done(15, nd);
    check("rst_no_done", 64'(nd), 64'd0);
    @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h7F;
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    wait_done(lat, nbusy, ovl);
    check("b2b_first_lat", 64'(lat), 64'd9);
    check("b2b_first", {borrow_out, diff}, {1'b0, 8'h01});
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_bubble", 64'(busy), 64'd1);
    wait_done(lat, nbusy, ovl);
    check("b2b_spacing", 64'(lat), 64'd9);
    check("b2b_second", {borrow_out, diff}, {1'b1, 8'hFF});
    for (int n = 0; n < 1000; n++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      x13 = 13'($urandom);
      y13 = 13'($urandom);
      if (n % 50 == 0) y8 = x8;
      if (n % 50 == 1) y13 = x13;
      @(negedge clk);
      start = 1'b1;
      start13 = 1'b1;
      a = x8;
      b = y8;
      a13 = x13;
      b13 = y13;
      @(negedge clk);
      start = 1'b0;
      start13 = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      a13 = 13'($urandom);
      b13 = 13'($urandom);
      g8 = 1'b0;
      g13 = 1'b0;
      for (int i = 1; i <= 20 && !(g8 && g13); i++) begin
        if (done && !g8) begin
          g8 = 1'b1;
          check("rand8", {borrow_out, diff}, {x8 < y8, 8'(x8 - y8)});
        end
        if (done13 && !g13) begin
          g13 = 1'b1;
          check("rand13", {bo13, diff13}, {x13 < y13, 13'(x13 - y13)});
        end
        @(negedge clk);
      end
      check("rand_done_seen", {g8, g13}, 2'b11);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction controller: computes a - b (unsigned, WIDTH bits) by sequencing one shared 1-bit full subtractor over WIDTH cycles, LSB first.
- Holds the borrow between bits in a register, assembles the difference in a shift register, and reports completion with a start/busy/done handshake.
- Sits above the existing full-subtractor cells. It trades area for latency when one subtractor is shared across a whole word.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction. Sampled only in IDLE or DONE.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  a - b mod 2^WIDTH. Held until next accepted start.
- borrow_out  output  1  final borrow (1 iff a < b). Held with diff.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Operand shift registers, borrow register and counter are cleared.
  - Reset during RUN aborts the operation; no done is produced.
- States:
  - IDLE: start=1 -> load a_sr<=a, b_sr<=b, brw<=0, cnt<=0, go to RUN. Otherwise stay.
  - RUN: each cycle the full subtractor computes d = a_sr[0]^b_sr[0]^brw.
    - Borrow: bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&brw).
    - Shift a_sr/b_sr right by 1; shift d into res_sr MSB (right shift); brw<=bo; cnt<=cnt+1.
    - When cnt==WIDTH-1 (last bit): go to DONE; diff<=final res_sr; borrow_out<=bo.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> reload and go to RUN (back-to-back, no idle bubble).
    - Otherwise go to IDLE.
- start while in RUN is ignored. Operands are not re-sampled and the current operation is unaffected.
- a/b may change freely after the accepting edge; only captured values are used.
- Latency: start accepted at edge k; RUN occupies WIDTH cycles; done is high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- busy=1 exactly in RUN; done and busy are never high together.
- diff/borrow_out update only on entry to DONE. They stay stable through IDLE, through the next RUN, and until the next DONE.
- Arithmetic: unsigned modulo 2^WIDTH. No overflow flag; borrow_out is the only range indication.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as named constants; default WIDTH.
- Sub-module: full_sub (A, B, BorrowIn -> D, BorrowOut), a single behavioural 1-bit full subtractor instantiated once. The controller never duplicates its logic inline.
- FSM, counter and shift registers stay in serial_sub_ctrl.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, start pulse -> busy for 8 cycles, done in 9th cycle after accept, diff=8'h1E, borrow_out=0.
- a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1; a=8'hA7, b=8'hA7 -> diff=8'h00, borrow_out=0.
- Start a=8'h10, b=8'h01; pulse start with a=8'hFF, b=8'h00 at RUN cycle 3 -> second start ignored, diff=8'h0F, single done pulse.
- Assert rst for 1 cycle at RUN cycle 4 -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done afterwards until a new start.
- Hold start=1 continuously with a=8'h80, b=8'h7F, then a=8'h01, b=8'h02 -> results 8'h01 (borrow 0) then 8'hFF (borrow 1), done pulses exactly 9 cycles apart, no IDLE cycle between.
- Random sweep, 1000 operand pairs, WIDTH=8 and WIDTH=13 -> {borrow_out,diff} equals {a<b, (a-b) mod 2^WIDTH} against a reference model.
